// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types and constants for the product-to-BCD converter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Elaboration-time 10^n, used to size the overflow threshold.
    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_add3_digit.sv
// ============================================================================
// Module  : bcd_add3_digit
// Brief   : Double-dabble digit correction, adds 3 when the digit is >= 5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3_digit

`default_nettype wire

// File: rtl/product_bcd_converter.sv
// ============================================================================
// Module  : product_bcd_converter
// Brief   : Serial binary-to-packed-BCD converter with valid/ready handshakes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module product_bcd_converter
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 5,
    parameter int DIGITS   = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_overflow
);

    localparam int c_BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int c_SR_W  = IN_WIDTH + c_BCD_W;
    localparam int c_CNT_W = $clog2(IN_WIDTH + 1);

    // Threshold held at full shift-register width so the compare never truncates.
    localparam logic [c_SR_W-1:0]  c_MAX_VAL = c_SR_W'(pow10(DIGITS) - 1);
    localparam logic [c_CNT_W-1:0] c_LOAD    = c_CNT_W'(IN_WIDTH);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_SR_W-1:0]   r_shift;
    logic                r_overflow;

    logic [c_BCD_W-1:0]  w_bcd_adj;
    logic [c_SR_W-1:0]   w_shift_adj;
    logic [c_SR_W-1:0]   w_in_ext;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3_digit u_add3 (
                .i_digit (r_shift[IN_WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign w_shift_adj = {w_bcd_adj, r_shift[IN_WIDTH-1:0]};
    assign w_in_ext    = {{c_BCD_W{1'b0}}, in_data};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_shift    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift    <= w_in_ext;
                        r_count    <= c_LOAD;
                        r_overflow <= (w_in_ext > c_MAX_VAL);
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top digit's carry is dropped, which yields value mod 10^DIGITS.
                    r_shift <= {w_shift_adj[c_SR_W-2:0], 1'b0};
                    r_count <= r_count - c_ONE;
                    if (r_count == c_ONE) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign out_bcd      = r_shift[c_SR_W-1 -: c_BCD_W];
    assign out_overflow = r_overflow;

endmodule : product_bcd_converter

`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
// ============================================================================
// Module  : tb_product_bcd_converter
// Brief   : Self-checking bench for the 5-bit and 7-bit BCD converters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_bcd_converter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_overflow;
    logic [4:0] in_data;
    logic [7:0] out_bcd;

    logic       wd_in_valid, wd_in_ready, wd_out_valid, wd_out_ready, wd_out_overflow;
    logic [6:0] wd_in_data;
    logic [7:0] wd_out_bcd;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    product_bcd_converter #(.IN_WIDTH(5), .DIGITS(2)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_overflow(out_overflow)
    );

    product_bcd_converter #(.IN_WIDTH(7), .DIGITS(2)) u_dut_wide (
        .clock(clock), .reset_n(reset_n),
        .in_valid(wd_in_valid), .in_ready(wd_in_ready), .in_data(wd_in_data),
        .out_valid(wd_out_valid), .out_ready(wd_out_ready),
        .out_bcd(wd_out_bcd), .out_overflow(wd_out_overflow)
    );

    // Reference: decimal digits of (v mod 100), packed tens:units.
    function automatic logic [7:0] ref_bcd(input int v);
        int m;
        m = v % 100;
        return 8'(((m / 10) * 16) + (m % 10));
    endfunction

    task automatic start_and_wait(input logic [4:0] v, input bit noise, output int lat);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clock);
        lat = 1;
        if (noise) begin
            in_valid = 1'b1;
            in_data  = 5'd7;
        end else begin
            in_valid = 1'b0;
            in_data  = 5'($urandom);
        end
        while (!out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic start_and_wait_w(input logic [6:0] v, output int lat);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!wd_in_ready && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        wd_in_valid = 1'b1;
        wd_in_data  = v;
        @(negedge clock);
        lat = 1;
        wd_in_valid = 1'b0;
        wd_in_data  = 7'($urandom);
        while (!wd_out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b1; in_data = 5'd31; out_ready = 1'b1;
        wd_in_valid = 1'b1; wd_in_data = 7'd100; wd_out_ready = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_bcd !== 8'h00) begin bad++; $display("FAIL reset_out_bcd: got %h want 00", out_bcd); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", out_overflow); end
        total++; if (wd_in_ready !== 1'b1 || wd_out_bcd !== 8'h00) begin
            bad++; $display("FAIL reset_wide: got ready=%b bcd=%h want 1/00", wd_in_ready, wd_out_bcd);
        end
        in_valid = 1'b0; out_ready = 1'b0; wd_in_valid = 1'b0; wd_out_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_first_31;
        int lat;
        start_and_wait(5'd31, 1'b0, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL latency_31: got %0d want 6", lat); end
        total++; if (out_bcd !== 8'h31) begin bad++; $display("FAIL bcd_31: got %h want 31", out_bcd); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL ovf_31: got %b want 0", out_overflow); end
        release_out();
    endtask

    task automatic test_sweep;
        int order[32];
        int lat, j, tmp;
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 32; i++) begin
            start_and_wait(5'(order[i]), 1'b0, lat);
            total++; if (lat !== 6) begin bad++; $display("FAIL sweep_latency v=%0d: got %0d want 6", order[i], lat); end
            total++; if (out_bcd !== ref_bcd(order[i])) begin
                bad++; $display("FAIL sweep_bcd v=%0d: got %h want %h", order[i], out_bcd, ref_bcd(order[i]));
            end
            total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL sweep_ovf v=%0d: got %b want 0", order[i], out_overflow); end
            repeat ($urandom_range(0, 2)) @(negedge clock);
            release_out();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int v;
        v = int'($urandom_range(10, 31));
        start_and_wait(5'(v), 1'b0, lat);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            total++; if (out_valid !== 1'b1 || out_bcd !== ref_bcd(v) || in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d: got valid=%b bcd=%h ready=%b want 1/%h/0", c, out_valid, out_bcd, in_ready, ref_bcd(v));
            end
        end
        release_out();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_ignore_in_valid;
        int lat;
        start_and_wait(5'd12, 1'b1, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL ignore_latency: got %0d want 6", lat); end
        total++; if (out_bcd !== 8'h12) begin bad++; $display("FAIL ignore_bcd: got %h want 12", out_bcd); end
        release_out();
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clock);
        in_valid = 1'b1; in_data = 5'd20;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL midreset_state: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        total++; if (out_bcd !== 8'h00) begin bad++; $display("FAIL midreset_bcd: got %h want 00", out_bcd); end
        start_and_wait(5'd25, 1'b0, lat);
        total++; if (out_bcd !== 8'h25 || lat !== 6) begin
            bad++; $display("FAIL after_reset_25: got bcd=%h lat=%0d want 25/6", out_bcd, lat);
        end
        release_out();
    endtask

    task automatic test_back_to_back;
        int t, t1, t2, v;
        v = int'($urandom_range(0, 31));
        out_ready = 1'b1; in_valid = 1'b1; in_data = 5'(v);
        t = 0;
        while (!out_valid && t < 40) begin @(negedge clock); t++; end
        t1 = t;
        total++; if (out_bcd !== ref_bcd(v)) begin bad++; $display("FAIL b2b_bcd: got %h want %h", out_bcd, ref_bcd(v)); end
        @(negedge clock); t++;
        while (!out_valid && t < 80) begin @(negedge clock); t++; end
        t2 = t;
        total++; if (t2 - t1 !== 7) begin bad++; $display("FAIL b2b_period: got %0d want 7", t2 - t1); end
        in_valid = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_wide;
        int vals[8];
        int lat;
        vals[0] = 100; vals[1] = 99; vals[2] = 127; vals[3] = 0;
        for (int i = 4; i < 8; i++) vals[i] = int'($urandom_range(0, 127));
        for (int i = 0; i < 8; i++) begin
            start_and_wait_w(7'(vals[i]), lat);
            total++; if (lat !== 8) begin bad++; $display("FAIL wide_latency v=%0d: got %0d want 8", vals[i], lat); end
            total++; if (wd_out_bcd !== ref_bcd(vals[i])) begin
                bad++; $display("FAIL wide_bcd v=%0d: got %h want %h", vals[i], wd_out_bcd, ref_bcd(vals[i]));
            end
            total++; if (wd_out_overflow !== (vals[i] > 99)) begin
                bad++; $display("FAIL wide_ovf v=%0d: got %b want %b", vals[i], wd_out_overflow, vals[i] > 99);
            end
            wd_out_ready = 1'b1;
            @(negedge clock);
            wd_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_first_31();
        test_sweep();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule : tb_product_bcd_converter

`default_nettype wire
